// File: rtl/trade_report_tx_if.sv
// Trade-report port bundle: matching-engine strobe and trade fields in, UART line and status out.
interface trade_report_tx_if;
  logic       match_flag;
  logic [7:0] trade_price;
  logic [7:0] best_bid;
  logic [7:0] best_ask;
  logic       tx;
  logic       busy;
  logic       overflow;
  logic [7:0] dropped_count;

  modport master (
    output match_flag, trade_price, best_bid, best_ask,
    input  tx, busy, overflow, dropped_count
  );

  modport slave (
    input  match_flag, trade_price, best_bid, best_ask,
    output tx, busy, overflow, dropped_count
  );
endinterface

// File: rtl/trade_report_tx.sv
// Buffers trade events and sends each as a 5-byte 8N1 UART frame (A5, price, bid, ask, xor).
// tx lags the FSM by one register stage; full FIFO drops new trades and counts them.
module trade_report_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 4
) (
  input logic              clk,
  input logic              reset,
  trade_report_tx_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]   FIFO_FULL = (AW+1)'(FIFO_DEPTH);

  typedef struct packed {
    logic [7:0] price;
    logic [7:0] bid;
    logic [7:0] ask;
  } trade_t;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  trade_t        fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          fifo_full;
  logic          fifo_empty;
  logic          push;
  logic          pop;
  logic          drop;

  state_t        state;
  state_t        state_nxt;
  logic [BW-1:0] baud_cnt;
  logic [BW-1:0] baud_nxt;
  logic [2:0]    bit_cnt;
  logic [2:0]    bit_nxt;
  logic [2:0]    byte_cnt;
  logic [2:0]    byte_nxt;
  logic          baud_done;
  trade_t        cur;
  logic [7:0]    cur_byte;
  logic          tx_q;
  logic          busy_q;
  logic          overflow_q;
  logic [7:0]    dropped_q;

  // Fullness is judged on the pre-pop count, so a pop never rescues a same-cycle push.
  assign fifo_full  = (count == FIFO_FULL);
  assign fifo_empty = (count == '0);
  assign push       = bus.match_flag & ~fifo_full;
  assign drop       = bus.match_flag & fifo_full;
  assign pop        = (state == IDLE) & ~fifo_empty;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= '{price: bus.trade_price, bid: bus.best_bid, ask: bus.best_ask};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow_q <= 1'b0;
      dropped_q  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop) begin
        overflow_q <= 1'b1;
        if (dropped_q != 8'hFF) dropped_q <= dropped_q + 1'b1;
      end
    end
  end

  assign baud_done = (baud_cnt == BAUD_LAST);

  always_comb begin
    state_nxt = state;
    baud_nxt  = baud_cnt;
    bit_nxt   = bit_cnt;
    byte_nxt  = byte_cnt;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          state_nxt = START;
          baud_nxt  = '0;
          bit_nxt   = '0;
          byte_nxt  = '0;
        end
      end
      START: begin
        if (baud_done) begin
          state_nxt = DATA;
          baud_nxt  = '0;
        end else begin
          baud_nxt = baud_cnt + 1'b1;
        end
      end
      DATA: begin
        if (baud_done) begin
          baud_nxt = '0;
          if (bit_cnt == 3'd7) begin
            state_nxt = STOP;
            bit_nxt   = '0;
          end else begin
            bit_nxt = bit_cnt + 3'd1;
          end
        end else begin
          baud_nxt = baud_cnt + 1'b1;
        end
      end
      STOP: begin
        if (baud_done) begin
          baud_nxt = '0;
          if (byte_cnt == 3'd4) begin
            state_nxt = IDLE;
            byte_nxt  = '0;
          end else begin
            state_nxt = START;
            byte_nxt  = byte_cnt + 3'd1;
          end
        end else begin
          baud_nxt = baud_cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cur_byte = cur.price ^ cur.bid ^ cur.ask;
    case (byte_cnt)
      3'd0:    cur_byte = 8'hA5;
      3'd1:    cur_byte = cur.price;
      3'd2:    cur_byte = cur.bid;
      3'd3:    cur_byte = cur.ask;
      default: cur_byte = cur.price ^ cur.bid ^ cur.ask;
    endcase
  end

  // tx and busy are both registered from the current state, so they stay aligned with each other.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      byte_cnt <= '0;
      cur      <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state    <= state_nxt;
      baud_cnt <= baud_nxt;
      bit_cnt  <= bit_nxt;
      byte_cnt <= byte_nxt;
      if (pop) cur <= fifo_mem[rd_ptr];
      case (state)
        START:   tx_q <= 1'b0;
        DATA:    tx_q <= cur_byte[bit_cnt];
        default: tx_q <= 1'b1;
      endcase
      busy_q <= (state != IDLE) | ~fifo_empty;
    end
  end

  assign bus.tx            = tx_q;
  assign bus.busy          = busy_q;
  assign bus.overflow      = overflow_q;
  assign bus.dropped_count = dropped_q;
endmodule

// File: doc/trade_report_tx.md
TRADE_REPORT_TX -- requirements
Module: trade_report_tx

Interface
REQ-001 Parameter: CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200 baud).
REQ-002 Parameter: FIFO_DEPTH, 4, trade entries buffered; power of two, at least 2.
REQ-003 clk  input  1  system clock; all logic on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 match_flag  input  1  one-cycle trade event strobe from the matching engine.
REQ-006 trade_price  input  8  executed price, valid while match_flag=1.
REQ-007 best_bid  input  8  best bid, valid while match_flag=1.
REQ-008 best_ask  input  8  best ask, valid while match_flag=1.
REQ-009 tx  output  1  UART serial line, idle high.
REQ-010 busy  output  1  high while a frame is in flight or the FIFO is non-empty.
REQ-011 overflow  output  1  sticky flag, set when any trade is dropped.
REQ-012 dropped_count  output  8  number of dropped trades, saturating.

Function
REQ-013 Capture: on each edge with match_flag=1, the block SHALL push {trade_price, best_bid, best_ask} into the FIFO if it is not full.
- Fullness is evaluated before any same-cycle pop.
REQ-014 Drop: match_flag=1 while the FIFO is full SHALL discard the entry, set overflow, and increment dropped_count.
- dropped_count saturates at 255 and never wraps.
REQ-015 Frame format: 5 bytes in this order:
- 0xA5 (sync)
- price
- bid
- ask
- checksum = price XOR bid XOR ask
REQ-016 Byte format: 8N1 serialisation.
- Start bit 0, then data bits LSB first, then stop bit 1.
- Every bit holds for exactly CLKS_PER_BIT cycles.
REQ-017 FSM states: IDLE, START, DATA, STOP.
- IDLE->START: FIFO non-empty; the entry is popped and latched on the same edge.
- START->DATA: after CLKS_PER_BIT cycles.
- DATA->STOP: after 8 bits.
- STOP->START: next byte of the frame, if bytes remain.
- STOP->IDLE: after the fifth byte.
REQ-018 Latency: tx SHALL fall at the second rising edge after the edge that samples match_flag=1, when the block is IDLE with the FIFO empty.
REQ-019 Frame duration: exactly 50*CLKS_PER_BIT cycles, with no gaps between bytes inside a frame.
REQ-020 Back-to-back frames: exactly one IDLE cycle with tx=1 separates the end of a stop bit from the next frame's start bit.
REQ-021 Latched entry: the entry is held for the whole frame; input or FIFO activity SHALL NOT alter a frame in flight.
REQ-022 tx SHALL be driven from a register (glitch-free).
REQ-023 busy = (state != IDLE) OR (FIFO non-empty), registered-consistent with state.
REQ-024 Simultaneous push and pop on a non-full FIFO SHALL leave the occupancy count unchanged and keep FIFO order.

Reset
REQ-025 Values after reset:
- tx=1, busy=0, overflow=0, dropped_count=0.
- FIFO empty, state IDLE.
- Bit counter, byte counter and baud counter cleared.
REQ-026 Reset mid-frame: the frame is aborted; tx=1 from the edge that samples reset=1; queued entries are discarded.
REQ-027 match_flag sampled in the same cycle as reset=1 SHALL be ignored.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-028 Reset: hold reset 3 cycles -> tx=1, busy=0, overflow=0, dropped_count=0; tx stays 1 with no stimulus.
REQ-029 Single trade: price=0x32, bid=0x35, ask=0x30, one pulse.
- tx falls 2 edges later.
- Bytes decoded: A5 32 35 30 37.
- Frame lasts 200 cycles; busy drops right after.
REQ-030 Overflow: 6 consecutive match_flag cycles from idle.
- 1 entry popped immediately, 4 queued, 1 dropped.
- overflow=1, dropped_count=1.
- Exactly 5 frames transmitted, in order.
REQ-031 Saturation: 300 pulses while the FIFO stays full.
- dropped_count=255 and does not wrap.
- overflow remains 1 until reset.
REQ-032 Reset mid-frame: reset during DATA of byte 2 with 2 entries queued.
- tx=1 from the reset edge.
- busy=0 after release; no further frames appear.
REQ-033 Back-to-back: two pulses 1 cycle apart.
- Second frame's start bit begins exactly 1 cycle after the first frame's final stop bit.
- Both frames carry their correct checksums.
